adc_capture_ctrl: RTL

ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

---
 rtl/adc_capture_pkg.sv | 21 ++
 rtl/adc_test_pattern.sv | 36 +++
 rtl/adc_capture_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC capture controller.
package adc_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int DEPTH_DEF = 8192;
  localparam int CNT_W     = 14;
  localparam int DEC_W     = 4;
  localparam int RAMP_W    = 12;

  localparam logic [1:0] BW_8B      = 2'b00;
  localparam logic [1:0] BW_10B     = 2'b01;
  localparam logic [1:0] BW_12B     = 2'b10;
  localparam logic [1:0] BW_12B_ALT = 2'b11;

endpackage

// File: rtl/adc_test_pattern.sv
// 12-bit ramp source; advances once per written sample, restarts on arm.
`ifdef TEST_PATTERN_EN
module adc_test_pattern
  import adc_capture_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              step,
  output logic [RAMP_W-1:0] ramp
);

  logic [RAMP_W-1:0] ramp_q;
  logic [RAMP_W-1:0] ramp_d;

  always_comb begin
    ramp_d = ramp_q;
    if (clr) begin
      ramp_d = '0;
    end else if (step) begin
      ramp_d = ramp_q + RAMP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ramp_q <= '0;
    end else begin
      ramp_q <= ramp_d;
    end
  end

  assign ramp = ramp_q;

endmodule
`endif

// File: rtl/adc_capture_ctrl.sv
// Armed/triggered ADC capture into a FIFO with decimation and resolution masking.
// Define TEST_PATTERN_EN to replace adc_data with an internal ramp.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              wrclk,
  input  logic              rst,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              arm,
  input  logic              trig,
  input  logic              sw_trig,
  input  logic              abort,
  input  logic [DEC_W-1:0]  decim,
  input  logic [1:0]        bw_bits,
  output logic [DATA_W-1:0] din,
  output logic              wren,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  wr_count
);

  localparam logic [DATA_W-1:0] ONES    = '1;
  localparam logic [DATA_W-1:0] MASK_8  = ONES << (DATA_W - 8);
  localparam logic [DATA_W-1:0] MASK_10 = ONES << (DATA_W - 10);

  state_e             state_q, state_d;
  logic               trig_q;
  logic [DEC_W-1:0]   dec_q, dec_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  din_q, din_d;
  logic               wren_q;
  logic [DATA_W-1:0]  sample;
  logic               arm_ok;
  logic               trig_hit;
  logic               wr_en;

  assign arm_ok   = arm && (state_q == ST_IDLE || state_q == ST_DONE);
  assign trig_hit = (trig & ~trig_q) | sw_trig;

`ifdef TEST_PATTERN_EN
  logic [RAMP_W-1:0] ramp;

  adc_test_pattern u_test_pattern (
    .clk  (wrclk),
    .rst  (rst),
    .clr  (arm_ok),
    .step (wr_en),
    .ramp (ramp)
  );

  assign sample = DATA_W'(ramp);
`else
  logic [DATA_W-1:0] adc_q;

  always_ff @(posedge wrclk) begin
    if (rst) begin
      adc_q <= '0;
    end else begin
      adc_q <= adc_data;
    end
  end

  assign sample = adc_q;
`endif

  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (trig_hit) begin
          state_d = ST_CAPTURE;
          dec_d   = '0;
        end
      end
      ST_CAPTURE: begin
        // down-counter reloads from decim only after a write
        if (dec_q == '0) begin
          wr_en = 1'b1;
          dec_d = decim;
        end else begin
          dec_d = dec_q - DEC_W'(1);
        end
        if (cnt_q == CNT_W'(DEPTH - 1)) begin
          if (wr_en) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (arm_ok) cnt_d = '0;
    if (abort) begin
      state_d = ST_IDLE;
      wr_en   = 1'b0;
    end
    if (wr_en) cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    din_d = din_q;
    if (wr_en) begin
      case (bw_bits)
        BW_8B:      din_d = sample & MASK_8;
        BW_10B:     din_d = sample & MASK_10;
        BW_12B:     din_d = sample;
        BW_12B_ALT: din_d = sample;
        default:    din_d = sample;
      endcase
    end
  end

  always_ff @(posedge wrclk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      trig_q  <= 1'b0;
      dec_q   <= '0;
      cnt_q   <= '0;
      din_q   <= '0;
      wren_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q  <= trig;
      dec_q   <= dec_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      wren_q  <= wr_en;
    end
  end

  assign din      = din_q;
  assign wren     = wren_q;
  assign busy     = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
  assign done     = (state_q == ST_DONE);
  assign wr_count = cnt_q;

endmodule
